// File: rtl/sram_pkg.sv
// Shared types for the parametrised single-port SRAM: FSM states,
// error-cause encoding and the lane-count helper.
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } sram_state_t;

    // Why an access was refused; the design does not use it, it exists so a bench can tally causes.
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BUSY    = 2'd1,
        ERR_COLLIDE = 2'd2,
        ERR_RANGE   = 2'd3
    } err_cause_t;

    function automatic int lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

// File: rtl/sram_out_pipe.sv
// Generic valid+data register stage: the data holds its last value until a new
// valid word arrives, and valid is a one-cycle strobe.
module sram_out_pipe
    import sram_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_i;
        data_d  = valid_i ? data_i : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/sram_sp_param.sv
// Parametrised single-port SRAM with post-reset auto-clear, lane write mask and
// registered read path. Define SRAM_OUT_REG_EN for an extra output stage (2-cycle read latency).
module sram_sp_param
    import sram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs,
    input  logic                     rd,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W/LANE_W-1:0] wmask,
    input  logic [DATA_W-1:0]        data_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     err
);

    localparam int                LANES     = lanes(DATA_W, LANE_W);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    sram_state_t       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              req;
    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [LANES-1:0]  mem_lanes;
    logic              rd_fire;
    logic [DATA_W-1:0] rd_word;

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        req       = cs && (rd || we);
        in_range  = {1'b0, addr} < DEPTH_EXT;
        mem_we    = 1'b0;
        mem_addr  = addr;
        mem_wdata = data_i;
        mem_lanes = wmask;
        rd_fire   = 1'b0;
        rd_word   = '0;
        err_d     = 1'b0;

        case (state_q)
            CLEAR: begin
                // The clear sweep owns the write port; any bus request is refused.
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = '0;
                mem_lanes = '1;
                ptr_d     = ptr_q + 1'b1;
                err_d     = req;
                if (ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs) begin
                    if (rd && we) begin
                        err_d = 1'b1;
                    end else if (we) begin
                        mem_we = in_range;
                        err_d  = !in_range;
                    end else if (rd) begin
                        // Out-of-range reads still complete, returning zero.
                        rd_fire = 1'b1;
                        rd_word = in_range ? mem[addr] : '0;
                        err_d   = !in_range;
                    end
                end
            end
        endcase

        busy_d = (state_d == CLEAR);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array has no reset; the clear FSM zeroes it so it still maps onto plain SRAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_lanes[i]) begin
                    mem[mem_addr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;

    sram_out_pipe #(.W(DATA_W)) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rd_fire),
        .data_i  (rd_word),
        .valid_o (s1_valid),
        .data_o  (s1_data)
    );

`ifdef SRAM_OUT_REG_EN
    sram_out_pipe #(.W(DATA_W)) u_out_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (s1_valid),
        .data_i  (s1_data),
        .valid_o (rd_valid),
        .data_o  (data_o)
    );
`else
    assign rd_valid = s1_valid;
    assign data_o   = s1_data;
`endif

    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_sram_sp_param.sv
// Self-checking bench for sram_sp_param (32-bit words, 8-bit lanes, 200 words of 256 addressable).
module tb_sram_sp_param;
    import sram_pkg::*;

    localparam int DATA_W = 32;
    localparam int LANE_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;
    localparam int LANES  = DATA_W / LANE_W;
`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              cs = 1'b0, rd = 1'b0, we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [LANES-1:0]  wmask = '0;
    logic [DATA_W-1:0] data_i = '0;
    logic [DATA_W-1:0] data_o;
    logic              rd_valid, busy, err;

    sram_sp_param #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .rd       (rd),
        .we       (we),
        .addr     (addr),
        .wmask    (wmask),
        .data_i   (data_i),
        .data_o   (data_o),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err      (err)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: whole-word array, busy countdown and a read-result delay line.
    typedef struct {
        bit                valid;
        logic [DATA_W-1:0] data;
    } rd_t;

    rd_t               pipe_q[$];
    logic [DATA_W-1:0] mdl_mem [DEPTH];
    bit                mdl_busy;
    int                clear_left;
    logic [DATA_W-1:0] mdl_dout;
    bit                exp_valid, exp_err, exp_busy;
    logic [DATA_W-1:0] exp_data;
    int                cause_hits [4];

    task automatic model_reset();
        mdl_busy   = 1'b1;
        clear_left = DEPTH;
        mdl_dout   = '0;
        pipe_q.delete();
        for (int i = 0; i < LAT - 1; i++) pipe_q.push_back('{1'b0, '0});
    endtask

    // Drive one cycle at the falling edge, predict its outcome, return 1 time unit after the rising edge.
    task automatic step(input bit c, input bit r, input bit w, input logic [ADDR_W-1:0] a,
                        input logic [LANES-1:0] m, input logic [DATA_W-1:0] d);
        rd_t res;
        bit  inr;
        @(negedge clk);
        cs = c; rd = r; we = w; addr = a; wmask = m; data_i = d;
        res.valid = 1'b0;
        res.data  = '0;
        exp_err   = 1'b0;
        inr       = int'(a) < DEPTH;
        if (mdl_busy) begin
            exp_err = c && (r || w);
            if (exp_err) cause_hits[ERR_BUSY]++;
        end else if (c && r && w) begin
            exp_err = 1'b1;
            cause_hits[ERR_COLLIDE]++;
        end else if (c && (r || w) && !inr) begin
            exp_err = 1'b1;
            cause_hits[ERR_RANGE]++;
            res.valid = r;
        end else if (c && w) begin
            for (int i = 0; i < LANES; i++)
                if (m[i]) mdl_mem[a][i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
        end else if (c && r) begin
            res.valid = 1'b1;
            res.data  = mdl_mem[a];
        end
        if (mdl_busy) begin
            clear_left--;
            if (clear_left == 0) begin
                mdl_busy = 1'b0;
                foreach (mdl_mem[i]) mdl_mem[i] = '0;
            end
        end
        exp_busy = mdl_busy;
        pipe_q.push_back(res);
        res       = pipe_q.pop_front();
        exp_valid = res.valid;
        if (res.valid) mdl_dout = res.data;
        exp_data = mdl_dout;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Issue a read and wait out the read latency, capturing the first strobed result.
    task automatic read_word(input logic [ADDR_W-1:0] a, output bit got,
                             output logic [DATA_W-1:0] q, output bit e);
        step(1'b1, 1'b1, 1'b0, a, '0, '0);
        e   = err;
        got = 1'b0;
        q   = '0;
        for (int k = 1; k <= LAT; k++) begin
            if (rd_valid) begin
                got = 1'b1;
                q   = data_o;
                break;
            end
            idle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (data_o !== '0)   $display("FAIL reset_data_o: got %h want 0", data_o); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else pass_cnt++;
        total_cnt++; if (err !== 1'b0)    $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1)   $display("FAIL reset_busy: got %b want 1", busy); else pass_cnt++;
        release_reset();
    endtask

    task automatic test_clear();
        int n;
        bit saw_valid;
        bit got, e;
        logic [DATA_W-1:0] q;
        step(1'b1, 1'b1, 1'b0, 8'h05, '0, '0);
        total_cnt++; if (err !== 1'b1) $display("FAIL clear_rd_err: got %b want 1", err); else pass_cnt++;
        saw_valid = rd_valid;
        n = 1;
        while (busy === 1'b1 && n < DEPTH + 20) begin
            idle();
            saw_valid |= rd_valid;
            n++;
        end
        total_cnt++; if (saw_valid !== 1'b0) $display("FAIL clear_rd_valid: got %b want 0", saw_valid); else pass_cnt++;
        total_cnt++; if (n != DEPTH) $display("FAIL clear_cycles: got %0d want %0d", n, DEPTH); else pass_cnt++;
        read_word(8'h05, got, q, e);
        total_cnt++; if (got !== 1'b1) $display("FAIL clear_read_valid: got %b want 1", got); else pass_cnt++;
        total_cnt++; if (q !== '0) $display("FAIL clear_read_data: got %h want 0", q); else pass_cnt++;
    endtask

    task automatic test_write_read();
        step(1'b1, 1'b0, 1'b1, 8'h10, 4'hF, 32'h0000_00A5);
        total_cnt++; if (err !== 1'b0) $display("FAIL wr_err: got %b want 0", err); else pass_cnt++;
        step(1'b1, 1'b1, 1'b0, 8'h10, '0, '0);
        repeat (LAT - 1) idle();
        total_cnt++; if (rd_valid !== 1'b1) $display("FAIL rd_valid_lat: got %b want 1", rd_valid); else pass_cnt++;
        total_cnt++; if (data_o !== 32'h0000_00A5) $display("FAIL rd_data: got %h want 000000a5", data_o); else pass_cnt++;
        idle();
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL rd_valid_strobe: got %b want 0", rd_valid); else pass_cnt++;
        total_cnt++; if (data_o !== 32'h0000_00A5) $display("FAIL rd_data_hold: got %h want 000000a5", data_o); else pass_cnt++;
        step(1'b1, 1'b0, 1'b1, 8'h30, 4'hF, 32'h5A5A_0001);
        step(1'b1, 1'b1, 1'b0, 8'h30, '0, '0);
        repeat (LAT - 1) idle();
        total_cnt++; if (data_o !== 32'h5A5A_0001) $display("FAIL raw_data: got %h want 5a5a0001", data_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] got_q[$];
        int idx_q[$];
        step(1'b1, 1'b1, 1'b0, 8'h10, '0, '0);
        if (rd_valid) begin got_q.push_back(data_o); idx_q.push_back(0); end
        step(1'b1, 1'b1, 1'b0, 8'h11, '0, '0);
        if (rd_valid) begin got_q.push_back(data_o); idx_q.push_back(1); end
        for (int k = 2; k < 2 + LAT; k++) begin
            idle();
            if (rd_valid) begin got_q.push_back(data_o); idx_q.push_back(k); end
        end
        total_cnt++;
        if (got_q.size() != 2) $display("FAIL b2b_count: got %0d want 2", got_q.size());
        else if (got_q[0] !== 32'h0000_00A5 || got_q[1] !== '0)
            $display("FAIL b2b_data: got %h,%h want 000000a5,00000000", got_q[0], got_q[1]);
        else if (idx_q[1] != idx_q[0] + 1)
            $display("FAIL b2b_bubble: got gap %0d want 1", idx_q[1] - idx_q[0]);
        else pass_cnt++;
    endtask

    task automatic test_lane_mask();
        bit got, e;
        logic [DATA_W-1:0] q;
        step(1'b1, 1'b0, 1'b1, 8'h03, 4'hF, 32'h1122_3344);
        step(1'b1, 1'b0, 1'b1, 8'h03, 4'b0101, 32'hAABB_CCDD);
        read_word(8'h03, got, q, e);
        total_cnt++; if (q !== 32'h11BB_33DD) $display("FAIL lane_mask: got %h want 11bb33dd", q); else pass_cnt++;
        step(1'b1, 1'b0, 1'b1, 8'h03, 4'h0, 32'hFFFF_FFFF);
        total_cnt++; if (err !== 1'b0) $display("FAIL mask0_err: got %b want 0", err); else pass_cnt++;
        read_word(8'h03, got, q, e);
        total_cnt++; if (q !== 32'h11BB_33DD) $display("FAIL mask0_noop: got %h want 11bb33dd", q); else pass_cnt++;
    endtask

    task automatic test_collision();
        bit got, e;
        logic [DATA_W-1:0] q;
        step(1'b1, 1'b0, 1'b1, 8'h20, 4'hF, 32'hCAFE_BABE);
        step(1'b1, 1'b1, 1'b1, 8'h20, 4'hF, 32'h1234_5678);
        total_cnt++; if (err !== 1'b1) $display("FAIL coll_err: got %b want 1", err); else pass_cnt++;
        idle();
        total_cnt++; if (err !== 1'b0) $display("FAIL coll_err_strobe: got %b want 0", err); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL coll_rd_valid: got %b want 0", rd_valid); else pass_cnt++;
        read_word(8'h20, got, q, e);
        total_cnt++; if (q !== 32'hCAFE_BABE) $display("FAIL coll_mem: got %h want cafebabe", q); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        bit got, e;
        logic [DATA_W-1:0] q;
        read_word(8'h10, got, q, e);
        step(1'b1, 1'b0, 1'b1, 8'hF0, 4'hF, 32'hDEAD_BEEF);
        total_cnt++; if (err !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", err); else pass_cnt++;
        read_word(8'hF0, got, q, e);
        total_cnt++; if (e !== 1'b1) $display("FAIL oor_rd_err: got %b want 1", e); else pass_cnt++;
        total_cnt++; if (got !== 1'b1) $display("FAIL oor_rd_valid: got %b want 1", got); else pass_cnt++;
        total_cnt++; if (q !== '0) $display("FAIL oor_rd_data: got %h want 0", q); else pass_cnt++;
        step(1'b0, 1'b1, 1'b1, 8'hF0, 4'hF, 32'h0);
        total_cnt++; if (err !== 1'b0) $display("FAIL cs0_err: got %b want 0", err); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 4) == 0) ? ADDR_W'($urandom_range(DEPTH, 255))
                                            : ADDR_W'($urandom_range(0, 15));
            step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 a, LANES'($urandom_range(0, 15)), $urandom);
            total_cnt++; if (rd_valid !== exp_valid) $display("FAIL rnd_valid[%0d]: got %b want %b", n, rd_valid, exp_valid); else pass_cnt++;
            total_cnt++; if (data_o !== exp_data) $display("FAIL rnd_data[%0d]: got %h want %h", n, data_o, exp_data); else pass_cnt++;
            total_cnt++; if (err !== exp_err) $display("FAIL rnd_err[%0d]: got %b want %b", n, err, exp_err); else pass_cnt++;
            total_cnt++; if (busy !== exp_busy) $display("FAIL rnd_busy[%0d]: got %b want %b", n, busy, exp_busy); else pass_cnt++;
        end
        $display("error causes seen: busy=%0d collide=%0d range=%0d",
                 cause_hits[ERR_BUSY], cause_hits[ERR_COLLIDE], cause_hits[ERR_RANGE]);
    endtask

    task automatic test_reset_mid_clear();
        int n;
        bit got, e;
        logic [DATA_W-1:0] q;
        step(1'b1, 1'b0, 1'b1, 8'h12, 4'hF, 32'h0BAD_F00D);
        rst = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b1) $display("FAIL mid_rst_busy0: got %b want 1", busy); else pass_cnt++;
        repeat (2) @(posedge clk);
        release_reset();
        repeat (100) idle();
        total_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy100: got %b want 1", busy); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b1) $display("FAIL mid_rst_busy: got %b want 1", busy); else pass_cnt++;
        repeat (2) @(posedge clk);
        release_reset();
        n = 0;
        while (n < DEPTH + 20) begin
            idle();
            n++;
            if (busy !== 1'b1) break;
        end
        total_cnt++; if (n != DEPTH) $display("FAIL mid_clear_cycles: got %0d want %0d", n, DEPTH); else pass_cnt++;
        read_word(8'h12, got, q, e);
        total_cnt++; if (q !== '0) $display("FAIL mid_cleared: got %h want 0", q); else pass_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_back_to_back();
        test_lane_mask();
        test_collision();
        test_out_of_range();
        test_random();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
